// File: rtl/pfd_tdc.sv
`default_nettype none
// ============================================================================
// pfd_tdc : sampled phase-frequency detector with counter-based TDC,
//           cycle-slip flags and lock detector.
// Rev 1.0
// ============================================================================
module pfd_tdc #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_TOL    = 2,
  parameter int LOCK_CNT    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             ref_in,
  input  logic             fb_in,
  output logic             up,
  output logic             down,
  output logic [CNT_W:0]   err,
  output logic             err_valid,
  output logic             slip_up,
  output logic             slip_dn,
  output logic             locked
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LEAD_REF = 2'd1,
    LEAD_FB  = 2'd2
  } state_t;

  localparam int                  c_lock_w   = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0]    c_cnt_max  = '1;
  localparam logic [CNT_W:0]      c_lock_tol = (CNT_W+1)'(LOCK_TOL);
  localparam logic [c_lock_w-1:0] c_lock_cnt = c_lock_w'(LOCK_CNT);

  logic [SYNC_STAGES-1:0] r_ref_sync;
  logic [SYNC_STAGES-1:0] r_fb_sync;
  logic                   r_ref_dly;
  logic                   r_fb_dly;

  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [c_lock_w-1:0]    r_lock_cnt;
  logic                   r_slip_seen;

  logic                   w_e_ref;
  logic                   w_e_fb;
  logic [CNT_W-1:0]       w_cnt_inc;
  logic [CNT_W:0]         w_err_pos;
  logic [CNT_W:0]         w_err_neg;
  logic [CNT_W:0]         w_err_mag;
  logic                   w_in_tol;
  logic [c_lock_w-1:0]    w_lock_inc;

  // Both paths see identical latency, so the sync delay cancels in the measurement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ref_sync <= '0;
      r_fb_sync  <= '0;
      r_ref_dly  <= 1'b0;
      r_fb_dly   <= 1'b0;
    end else begin
      r_ref_sync <= {r_ref_sync[SYNC_STAGES-2:0], ref_in};
      r_fb_sync  <= {r_fb_sync[SYNC_STAGES-2:0], fb_in};
      r_ref_dly  <= r_ref_sync[SYNC_STAGES-1];
      r_fb_dly   <= r_fb_sync[SYNC_STAGES-1];
    end
  end

  assign w_e_ref    = r_ref_sync[SYNC_STAGES-1] & ~r_ref_dly;
  assign w_e_fb     = r_fb_sync[SYNC_STAGES-1] & ~r_fb_dly;
  assign w_cnt_inc  = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_err_pos  = {1'b0, r_cnt};
  assign w_err_neg  = -w_err_pos;
  assign w_err_mag  = err[CNT_W] ? -err : err;
  assign w_in_tol   = (w_err_mag <= c_lock_tol);
  assign w_lock_inc = (r_lock_cnt == c_lock_cnt) ? r_lock_cnt
                                                 : r_lock_cnt + c_lock_w'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      up        <= 1'b0;
      down      <= 1'b0;
      err       <= '0;
      err_valid <= 1'b0;
      slip_up   <= 1'b0;
      slip_dn   <= 1'b0;
    end else if (!en) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      up        <= 1'b0;
      down      <= 1'b0;
      err_valid <= 1'b0;
      slip_up   <= 1'b0;
      slip_dn   <= 1'b0;
    end else begin
      err_valid <= 1'b0;
      slip_up   <= 1'b0;
      slip_dn   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_e_ref && w_e_fb) begin
            err       <= '0;
            err_valid <= 1'b1;
          end else if (w_e_ref) begin
            r_state <= LEAD_REF;
            r_cnt   <= CNT_W'(1);
            up      <= 1'b1;
          end else if (w_e_fb) begin
            r_state <= LEAD_FB;
            r_cnt   <= CNT_W'(1);
            down    <= 1'b1;
          end
        end
        LEAD_REF: begin
          if (w_e_fb) begin
            err       <= w_err_pos;
            err_valid <= 1'b1;
            if (w_e_ref) begin
              // Coincident new ref edge opens the next measurement immediately.
              r_cnt <= CNT_W'(1);
            end else begin
              r_state <= IDLE;
              r_cnt   <= '0;
              up      <= 1'b0;
            end
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_e_ref) slip_up <= 1'b1;
          end
        end
        LEAD_FB: begin
          if (w_e_ref) begin
            err       <= w_err_neg;
            err_valid <= 1'b1;
            if (w_e_fb) begin
              r_cnt <= CNT_W'(1);
            end else begin
              r_state <= IDLE;
              r_cnt   <= '0;
              down    <= 1'b0;
            end
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_e_fb) slip_dn <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          up      <= 1'b0;
          down    <= 1'b0;
        end
      endcase
    end
  end

  // A slip poisons the next strobe as well, so lock restarts from a clean measurement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_cnt  <= '0;
      r_slip_seen <= 1'b0;
      locked      <= 1'b0;
    end else if (!en) begin
      r_lock_cnt  <= '0;
      r_slip_seen <= 1'b0;
      locked      <= 1'b0;
    end else if (slip_up || slip_dn) begin
      r_lock_cnt  <= '0;
      r_slip_seen <= 1'b1;
      locked      <= 1'b0;
    end else if (err_valid) begin
      r_slip_seen <= 1'b0;
      if (w_in_tol && !r_slip_seen) begin
        r_lock_cnt <= w_lock_inc;
        locked     <= (w_lock_inc == c_lock_cnt);
      end else begin
        r_lock_cnt <= '0;
        locked     <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pfd_tdc.sv
`default_nettype none
// ============================================================================
// tb_pfd_tdc : directed scoreboard bench for pfd_tdc (CNT_W=8 and CNT_W=4).
// Rev 1.0
// ============================================================================
module tb_pfd_tdc;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic       ref_in = 1'b0, fb_in = 1'b0;
  logic       up, down, err_valid, slip_up, slip_dn, locked;
  logic [8:0] err;

  logic       ref4 = 1'b0, fb4 = 1'b0;
  logic       up4, down4, ev4, su4, sd4, lk4;
  logic [4:0] err4;

  int n_checks = 0;
  int n_pass   = 0;

  logic [8:0] q[$];
  logic [4:0] q4[$];

  always #5 clk = ~clk;

  pfd_tdc #(.CNT_W(8), .SYNC_STAGES(2), .LOCK_TOL(2), .LOCK_CNT(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ref_in(ref_in), .fb_in(fb_in),
    .up(up), .down(down), .err(err), .err_valid(err_valid),
    .slip_up(slip_up), .slip_dn(slip_dn), .locked(locked)
  );

  pfd_tdc #(.CNT_W(4), .SYNC_STAGES(2), .LOCK_TOL(2), .LOCK_CNT(16)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .ref_in(ref4), .fb_in(fb4),
    .up(up4), .down(down4), .err(err4), .err_valid(ev4),
    .slip_up(su4), .slip_dn(sd4), .locked(lk4)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else
      n_pass++;
  endtask

  // Scoreboard monitors: every strobe must match the oldest expected error.
  always @(negedge clk) begin
    if (err_valid) begin
      check("err_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) check("err", 32'(err), 32'(q.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (ev4) begin
      check("err4_expected", 32'(q4.size() != 0), 32'd1);
      if (q4.size() != 0) check("err4", 32'(err4), 32'(q4.pop_front()));
    end
  end

  // One 40-cycle period: ref rises at cycle ra, fb at cycle fa, each high 20 cycles.
  task automatic run_period(input int ra, input int fa, input bit exp_strobe,
                            output bit lk_at, output bit lk_after);
    int  ups = 0, dns = 0, slips = 0;
    bit  prev_ev = 1'b0;
    lk_at = 1'b0;
    lk_after = 1'b0;
    if (exp_strobe) q.push_back(9'(fa - ra));
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      ref_in = (c >= ra) && (c < ra + 20);
      fb_in  = (c >= fa) && (c < fa + 20);
      @(negedge clk);
      if (up) ups++;
      if (down) dns++;
      if (slip_up || slip_dn) slips++;
      if (prev_ev) lk_after = locked;
      if (err_valid) lk_at = locked;
      prev_ev = err_valid;
    end
    check("up_cycles", 32'(ups), 32'((exp_strobe && fa > ra) ? fa - ra : 0));
    check("down_cycles", 32'(dns), 32'((exp_strobe && ra > fa) ? ra - fa : 0));
    check("no_slip", 32'(slips), 32'd0);
  endtask

  initial begin
    bit a, b;
    int ups4, slips4, sdn4;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", {up, down, err, err_valid, slip_up, slip_dn, locked}, 32'd0);
    check("reset_out4", {up4, down4, err4, ev4, su4, sd4, lk4}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // ref leads by 5
    repeat (3) run_period(0, 5, 1'b1, a, b);
    // simultaneous edges
    repeat (2) run_period(2, 2, 1'b1, a, b);
    // fb leads by 3: err = 9'h1FD
    repeat (2) run_period(3, 0, 1'b1, a, b);
    check("err_neg3_pattern", 32'(err), 32'h1FD);

    // Lock acquisition with err=+1, then loss with err=+5
    for (int i = 1; i <= 16; i++) begin
      run_period(0, 1, 1'b1, a, b);
      if (i < 16) begin
        check("lock_early", 32'(b), 32'd0);
      end else begin
        check("lock_at_16th", 32'(a), 32'd0);
        check("lock_after_16th", 32'(b), 32'd1);
      end
    end
    run_period(0, 5, 1'b1, a, b);
    check("lock_before_loss", 32'(a), 32'd1);
    check("lock_lost", 32'(b), 32'd0);

    // Disabled: no strobes, no up/down
    en = 1'b0;
    run_period(0, 5, 1'b0, a, b);
    check("en0_locked", 32'(locked), 32'd0);
    en = 1'b1;
    repeat (2) @(posedge clk);
    run_period(0, 2, 1'b1, a, b);

    // Reset mid-measurement
    @(posedge clk); #1;
    ref_in = 1'b1;
    for (int i = 0; i < 10 && !up; i++) @(negedge clk);
    check("mid_up_high", 32'(up), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_out", {up, down, err, err_valid, slip_up, slip_dn, locked}, 32'd0);
    ref_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    run_period(0, 4, 1'b1, a, b);

    // CNT_W=4: ref toggles with fb low, then a single fb edge
    ups4 = 0; slips4 = 0; sdn4 = 0;
    q4.push_back(5'd15);
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      ref4 = (c < 40) && ((c % 10) < 5);
      fb4  = (c >= 50);
      @(negedge clk);
      if (up4) ups4++;
      if (su4) slips4++;
      if (sd4 || down4) sdn4++;
    end
    check("sat_up_cycles", 32'(ups4), 32'd50);
    check("sat_slip_up", 32'(slips4), 32'd3);
    check("sat_no_down", 32'(sdn4), 32'd0);
    check("sat_idle_after", 32'(up4), 32'd0);
    fb4 = 1'b0;

    repeat (10) @(posedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    check("queue4_drained", 32'(q4.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
